// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions: BCD geometry, saturation limit, converter
// state encoding and a digit bundle the scan driver can reuse.
package disp_pkg;

    localparam int BCD_W     = 4;
    localparam int N_DIGITS  = 4;
    localparam int MAX_VAL   = 9999;
    localparam int CONV_BITS = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    typedef struct packed {
        logic [BCD_W-1:0] kilo;
        logic [BCD_W-1:0] hundred;
        logic [BCD_W-1:0] ten;
        logic [BCD_W-1:0] single;
    } bcd_digits_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between a value producer and the converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] bin_in;
    logic [3:0]       single_digit;
    logic [3:0]       ten_digit;
    logic [3:0]       hundred_digit;
    logic [3:0]       kilo_digit;
    logic             out_valid;
    logic             overflow;

    modport master (
        output in_valid, bin_in,
        input  in_ready, single_digit, ten_digit, hundred_digit, kilo_digit,
               out_valid, overflow
    );

    modport slave (
        input  in_valid, bin_in,
        output in_ready, single_digit, ten_digit, hundred_digit, kilo_digit,
               out_valid, overflow
    );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: a digit of 5 or more would carry past 9
// after the next doubling, so it is pre-biased by 3.
module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter feeding a 4-digit scan driver.
// Saturates at MAX_VAL, converts one bit per clock, and updates the
// registered digits only when a conversion completes.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic          clk,
    input  logic          rstn,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_TOT_W = BCD_W * N_DIGITS;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS - 1);

    conv_state_e            state, state_nxt;
    logic [CONV_BITS-1:0]   shreg;
    logic [BCD_TOT_W-1:0]   bcd_work;
    logic [BCD_TOT_W-1:0]   bcd_adj;
    logic [BCD_TOT_W-1:0]   bcd_shift;
    logic [CONV_BITS-1:0]   sh_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   ovf_pend;
    bcd_digits_t            digits;
    logic                   overflow_q;
    logic                   out_valid_q;
    logic                   in_ready;
    logic                   accept;
    logic                   in_over;
    logic [CONV_BITS-1:0]   sat;

    assign in_ready = (state == IDLE);
    assign accept   = bus.in_valid && in_ready;
    assign in_over  = bus.bin_in > BIN_W'(MAX_VAL);
    assign sat      = in_over ? CONV_BITS'(MAX_VAL) : bus.bin_in[CONV_BITS-1:0];

    // Per-digit add-3 correction ahead of each shift.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_in  (bcd_work[g*BCD_W +: BCD_W]),
            .nib_out (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    assign bcd_shift = {bcd_adj[BCD_TOT_W-2:0], shreg[CONV_BITS-1]};
    assign sh_shift  = {shreg[CONV_BITS-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, 14 shifts, one publish cycle.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift-and-add while busy, publish in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: every register here is plain flops, so all of them are reset; an abort leaves nothing stale.
        if (!rstn) begin
            shreg       <= '0;
            bcd_work    <= '0;
            bit_cnt     <= '0;
            ovf_pend    <= 1'b0;
            digits      <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= sat;
                        bcd_work <= '0;
                        bit_cnt  <= '0;
                        ovf_pend <= in_over;
                    end
                end
                SHIFT: begin
                    bcd_work <= bcd_shift;
                    shreg    <= sh_shift;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                end
                DONE: begin
                    digits.single  <= bcd_work[3:0];
                    digits.ten     <= bcd_work[7:4];
                    digits.hundred <= bcd_work[11:8];
                    digits.kilo    <= bcd_work[15:12];
                    overflow_q     <= ovf_pend;
                    out_valid_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.single_digit  = digits.single;
    assign bus.ten_digit     = digits.ten;
    assign bus.hundred_digit = digits.hundred;
    assign bus.kilo_digit    = digits.kilo;
    assign bus.out_valid     = out_valid_q;
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus a random
// sweep against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
    localparam int BIN_W = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] exp_digits = '0;
    logic        exp_ovf    = 1'b0;

    bin2bcd_seq_if #(.BIN_W(BIN_W)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: clamp to 9999, then split into decimal digits {k,h,t,s}.
    function automatic logic [15:0] ref_digits(input longint v);
        longint s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] obs_digits();
        return {bus.kilo_digit, bus.hundred_digit, bus.ten_digit, bus.single_digit};
    endfunction

    function automatic logic range_ok();
        return (bus.kilo_digit <= 4'd9) && (bus.hundred_digit <= 4'd9) &&
               (bus.ten_digit <= 4'd9) && (bus.single_digit <= 4'd9);
    endfunction

    // One full conversion: wait for idle, accept, scramble bin_in, time the result.
    task automatic do_conv(input logic [BIN_W-1:0] v);
        int lat;
        int w;
        bit stable_ok;
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.bin_in   = BIN_W'($urandom);
        stable_ok = 1'b1;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
            if (obs_digits() !== exp_digits || bus.overflow !== exp_ovf || bus.in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        check("latency", 32'(lat), 32'd15);
        check("stable_hold", 32'(stable_ok), 32'd1);
        exp_digits = ref_digits(longint'(v));
        exp_ovf    = (v > BIN_W'(9999));
        check("digits", 32'(obs_digits()), 32'(exp_digits));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check("in_ready_done", 32'(bus.in_ready), 32'd1);
        check("bcd_range", 32'(range_ok()), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit no_pulse;
        logic [15:0] seq_exp;

        bus.in_valid = 1'b0;
        bus.bin_in   = '0;
        rstn         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(obs_digits()), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic and boundary values.
        do_conv(16'd1234);
        do_conv(16'd0);
        do_conv(16'd9999);
        do_conv(16'd10000);
        do_conv(16'd65535);
        do_conv(16'd42);

        // in_valid held high, bin_in stepping 7,8,9 each cycle: accepts at
        // cycles 0,16,32 pick up 7, 8, 9; results appear 15 cycles later.
        for (int c = 0; c < 48; c++) begin
            bus.in_valid = 1'b1;
            bus.bin_in   = BIN_W'(7 + (c % 3));
            @(posedge clk); #1;
            if ((c % 16) == 15) begin
                seq_exp    = ref_digits(longint'(7 + ((c - 15) % 3)));
                exp_digits = seq_exp;
                exp_ovf    = 1'b0;
                check("b2b_pulse", 32'(bus.out_valid), 32'd1);
                check("b2b_digits", 32'(obs_digits()), 32'(exp_digits));
            end else begin
                check("b2b_no_pulse", 32'(bus.out_valid), 32'd0);
                check("b2b_hold", 32'(obs_digits()), 32'(exp_digits));
            end
        end
        bus.in_valid = 1'b0;

        // Abort a conversion with reset in the 8th SHIFT cycle.
        do_conv(16'd5678);
        bus.bin_in   = 16'd4321;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        check("abort_digits", 32'(obs_digits()), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_digits = '0;
        exp_ovf    = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        no_pulse = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) no_pulse = 1'b0;
        end
        check("abort_no_pulse", 32'(no_pulse), 32'd1);
        do_conv(16'd4321);

        // Random sweep, biased so both ranges get plenty of hits.
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) do_conv(BIN_W'($urandom_range(0, 9999)));
            else            do_conv(BIN_W'($urandom_range(0, 65535)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment scan driver.
- Accepts an unsigned binary value (counter, measurement, status word) through a valid/ready handshake.
- Converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Presents four registered BCD digits (single, ten, hundred, kilo) that drive the scan driver's digit inputs directly. Values above 9999 saturate to 9999 and raise a flag.

Parameters:
- BIN_W, 16, width of the binary input; legal range 14..32.
- MAX_VAL, 9999, saturation threshold; fixed by the 4-digit display.
- CONV_BITS, 14, shift iterations per conversion; ceil(log2(MAX_VAL+1)).

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  bin_in holds a value to convert.
- in_ready  output  1  converter is idle and can accept.
- bin_in  input  BIN_W  unsigned binary value.
- single_digit  output  4  BCD units digit.
- ten_digit  output  4  BCD tens digit.
- hundred_digit  output  4  BCD hundreds digit.
- kilo_digit  output  4  BCD thousands digit.
- out_valid  output  1  one-cycle pulse: digit outputs just updated.
- overflow  output  1  last converted input exceeded MAX_VAL.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Reset clears all digits to 0, out_valid=0, overflow=0, state=IDLE, and internal shift/BCD/count registers to 0. in_ready=1 once rstn deasserts.
- in_ready is combinational from state: 1 only in IDLE.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - Acceptance occurs on an edge with in_valid && in_ready.
  - On acceptance: sat = (bin_in > MAX_VAL) ? MAX_VAL : bin_in[CONV_BITS-1:0].
  - Load sat into a 14-bit shift register, clear the 16-bit BCD work register and the bit counter, latch ovf_pend = (bin_in > MAX_VAL), and move to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, shreg} left by 1.
  - The counter increments each cycle. On the edge where the counter equals CONV_BITS-1 (the 14th shift), move to DONE.
- DONE (one cycle): copy the BCD work nibbles [3:0], [7:4], [11:8], [15:12] to single/ten/hundred/kilo, copy ovf_pend to overflow, assert out_valid for the following cycle, and move to IDLE.
- Latency:
  - Acceptance at edge T0, outputs and overflow update at edge T0+15, out_valid high for the cycle after T0+15.
  - in_ready is high again in that same cycle.
  - Maximum throughput is one conversion per 16 cycles.
- Digit outputs and overflow hold their previous values for the whole conversion, so the scan driver never sees partial digits.
- in_valid while busy is ignored (in_ready=0). bin_in changes after acceptance have no effect.
- bin_in == MAX_VAL exactly gives overflow=0, digits 9,9,9,9. MAX_VAL+1 gives overflow=1, digits 9,9,9,9.
- Reset mid-conversion aborts immediately. No out_valid pulse, digits return to 0.
- in_valid held high continuously: a new conversion starts on every IDLE cycle (back-to-back, 16-cycle period).
- All digit outputs are always in 0..9; non-BCD codes are never produced.

Decomposition:
- Shared package (disp_pkg):
  - BCD_W=4, N_DIGITS=4, MAX_VAL=9999, CONV_BITS=14.
  - State enum {IDLE, SHIFT, DONE} with 2-bit encoding.
  - A bcd_digits struct/typedef of four 4-bit fields, reusable by the scan driver.
- One natural sub-module: bcd_add3, combinational nibble correction (out = in >= 5 ? in+3 : in). It is instantiated 4 times in SHIFT datapath generation.

Test Plan:
- After reset release, in_valid=1, bin_in=1234 -> out_valid pulse 15 cycles after acceptance; kilo/hundred/ten/single = 1/2/3/4; overflow=0; in_ready=1 that cycle.
- bin_in=0, then bin_in=9999 -> digits 0/0/0/0, then 9/9/9/9; overflow=0 both times.
- bin_in=10000, then bin_in=65535 -> digits 9/9/9/9 with overflow=1. A following bin_in=42 -> 0/0/4/2 with overflow cleared to 0.
- in_valid held high with bin_in stepping 7, 8, 9 every cycle -> only values sampled at acceptance edges (16-cycle spacing) are converted. Digits stay stable between out_valid pulses.
- Sequence 5678 converted, then 4321 accepted, then rstn pulsed low at cycle 8 of SHIFT -> digits drop to 0 asynchronously; no out_valid; in_ready=1 after release; next conversion of 4321 is correct.
- Random sweep of 2000 values in 0..2^BIN_W-1 against a reference model -> digits equal min(v,9999) in decimal; overflow = (v > 9999); all nibbles <= 9.
